// File: rtl/md5_match_checker.sv
// Compares a stream of MD5 digests from a hash core against a latched target
// and reports the first matching candidate or exhaustion of the search budget.
module md5_match_checker #(
    parameter int MAX_TRIES = 100000000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [127:0]     target_hash,
    input  logic             hash_valid,
    input  logic [127:0]     hash,
    input  logic [63:0]      cand,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [63:0]      found_pw,
    output logic [CNT_W-1:0] attempts
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        CMP     = 3'd2,
        FOUND   = 3'd3,
        EXHAUST = 3'd4
    } state_t;

    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(MAX_TRIES);

    state_t state;
    state_t state_nxt;

    logic [127:0] target;
    logic [127:0] skid_hash_p0;
    logic [63:0]  skid_cand_p0;
    logic         skid_vld_p0;
    logic [127:0] cap_hash_p1;
    logic [63:0]  cap_cand_p1;

    logic match;
    logic hit_limit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    assign match     = (cap_hash_p1 == target);
    assign hit_limit = (({1'b0, attempts} + (CNT_W+1)'(1)) == LIMIT);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        found     = 1'b0;
        exhausted = 1'b0;
        case (state)
            IDLE, FOUND, EXHAUST: begin
                if (start)
                    state_nxt = SEARCH;
            end
            SEARCH: begin
                if (skid_vld_p0 || hash_valid)
                    state_nxt = CMP;
            end
            CMP: begin
                // A match outranks the try limit landing on the same compare.
                if (match)
                    state_nxt = FOUND;
                else if (hit_limit)
                    state_nxt = EXHAUST;
                else
                    state_nxt = SEARCH;
            end
            default: state_nxt = IDLE;
        endcase
        busy      = (state == SEARCH) || (state == CMP);
        found     = (state == FOUND);
        exhausted = (state == EXHAUST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target       <= '0;
            skid_hash_p0 <= '0;
            skid_cand_p0 <= '0;
            skid_vld_p0  <= 1'b0;
            cap_hash_p1  <= '0;
            cap_cand_p1  <= '0;
            found_pw     <= '0;
            attempts     <= '0;
        end else begin
            case (state)
                IDLE, FOUND, EXHAUST: begin
                    if (start) begin
                        target      <= target_hash;
                        attempts    <= '0;
                        found_pw    <= '0;
                        skid_vld_p0 <= 1'b0;
                    end
                end
                // Capture stage: the skid entry is older, so it goes first.
                SEARCH: begin
                    if (skid_vld_p0) begin
                        cap_hash_p1 <= skid_hash_p0;
                        cap_cand_p1 <= skid_cand_p0;
                        skid_vld_p0 <= hash_valid;
                        if (hash_valid) begin
                            skid_hash_p0 <= hash;
                            skid_cand_p0 <= cand;
                        end
                    end else if (hash_valid) begin
                        cap_hash_p1 <= hash;
                        cap_cand_p1 <= cand;
                    end
                end
                // Compare stage: results arriving now park in the skid entry.
                CMP: begin
                    attempts <= sat_inc(attempts);
                    if (match)
                        found_pw <= cap_cand_p1;
                    if (hash_valid) begin
                        skid_hash_p0 <= hash;
                        skid_cand_p0 <= cand;
                        skid_vld_p0  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_match_checker.sv
// Bench for md5_match_checker: directed scenarios plus randomized searches,
// run on two instances with different try limits.
module tb_md5_match_checker;

    localparam int MA = 5;
    localparam int MB = 3;

    logic         clk = 1'b0;
    logic         reset, start, hash_valid;
    logic [127:0] target_hash, hash;
    logic [63:0]  cand;

    logic         busy_a, found_a, exh_a, busy_b, found_b, exh_b;
    logic [63:0]  pw_a, pw_b;
    logic [31:0]  att_a, att_b;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 0;

    logic [127:0] hq[16];
    logic [63:0]  cq[16];
    int           gq[16];
    logic [127:0] tgt;

    md5_match_checker #(.MAX_TRIES(MA), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
        .hash_valid(hash_valid), .hash(hash), .cand(cand),
        .busy(busy_a), .found(found_a), .exhausted(exh_a),
        .found_pw(pw_a), .attempts(att_a)
    );

    md5_match_checker #(.MAX_TRIES(MB), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
        .hash_valid(hash_valid), .hash(hash), .cand(cand),
        .busy(busy_b), .found(found_b), .exhausted(exh_b),
        .found_pw(pw_b), .attempts(att_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (run_chk) begin
            checks++;
            assert (!(found_a && exh_a) && !(found_b && exh_b)) else begin
                failures++;
                $error("FAIL excl observed=%b%b%b%b expected=no found+exhausted pair",
                       found_a, exh_a, found_b, exh_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of a search from the rules: compare in arrival order, stop at
    // the first match or when the number of compares reaches the limit.
    task automatic model(input int n, input int maxt, output bit f, output bit ex,
                         output int att, output logic [63:0] pw);
        f = 0; ex = 0; att = 0; pw = '0;
        for (int i = 0; i < n; i++) begin
            if (f || ex) break;
            att++;
            if (hq[i] == tgt) begin
                f  = 1;
                pw = cq[i];
            end else if (att == maxt) begin
                ex = 1;
            end
        end
    endtask

    task automatic check_both(input string tag, input int n);
        bit f, ex;
        int att;
        logic [63:0] pw;
        model(n, MA, f, ex, att, pw);
        chk({tag, ".a.found"}, found_a, f);
        chk({tag, ".a.exh"},   exh_a,   ex);
        chk({tag, ".a.att"},   att_a,   att);
        chk({tag, ".a.pw"},    pw_a,    pw);
        chk({tag, ".a.busy"},  busy_a,  !(f || ex));
        model(n, MB, f, ex, att, pw);
        chk({tag, ".b.found"}, found_b, f);
        chk({tag, ".b.exh"},   exh_b,   ex);
        chk({tag, ".b.att"},   att_b,   att);
        chk({tag, ".b.pw"},    pw_b,    pw);
        chk({tag, ".b.busy"},  busy_b,  !(f || ex));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic begin_search(input logic [127:0] t);
        tgt         = t;
        target_hash = t;
        start       = 1'b1;
        step();
        start       = 1'b0;
        target_hash = rnd128();
    endtask

    task automatic drive(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            hash_valid = 1'b1;
            hash       = hq[i];
            cand       = cq[i];
            step();
            hash_valid = 1'b0;
            hash       = rnd128();
            cand       = {$urandom, $urandom};
            for (int k = 1; k < gq[i]; k++) step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hash_valid = 1'b0;
        target_hash = '0; hash = '0; cand = '0;
        step(); step();
        reset = 1'b0;
        run_chk = 1;
        chk("rst.busy",  busy_a,  1'b0);
        chk("rst.found", found_a, 1'b0);
        chk("rst.exh",   exh_a,   1'b0);
        chk("rst.att",   att_a,   0);
        chk("rst.pw",    pw_a,    0);

        // Match on the fourth result, found two cycles after its pulse
        begin_search({16{8'hA5}});
        for (int i = 0; i < 3; i++) begin
            hq[i] = rnd128(); cq[i] = {$urandom, $urandom}; gq[i] = 3;
        end
        hq[3] = {16{8'hA5}}; cq[3] = 64'h3533353839373933; gq[3] = 1;
        drive(0, 2);
        hash_valid = 1'b1; hash = hq[3]; cand = cq[3];
        step();
        hash_valid = 1'b0;
        chk("m.lat1.found", found_a, 1'b0);
        step();
        chk("m.lat2.found", found_a, 1'b1);
        chk("m.pw",   pw_a,   64'h3533353839373933);
        chk("m.att",  att_a,  4);
        chk("m.busy", busy_a, 1'b0);
        repeat (3) step();
        check_both("m", 4);

        // Exhaustion with one surplus pulse
        do_reset();
        begin_search(rnd128());
        for (int i = 0; i < 6; i++) begin
            hq[i] = rnd128(); cq[i] = {$urandom, $urandom}; gq[i] = 2 + i % 2;
        end
        drive(0, 5);
        repeat (4) step();
        chk("x.exh",   exh_a,   1'b1);
        chk("x.att",   att_a,   5);
        chk("x.found", found_a, 1'b0);
        check_both("x", 6);

        // Match on the compare that also reaches the limit
        do_reset();
        begin_search(rnd128());
        for (int i = 0; i < 3; i++) begin
            hq[i] = rnd128(); cq[i] = {$urandom, $urandom}; gq[i] = 2;
        end
        hq[2] = tgt;
        drive(0, 2);
        repeat (4) step();
        chk("p.found", found_b, 1'b1);
        chk("p.exh",   exh_b,   1'b0);
        chk("p.att",   att_b,   3);
        check_both("p", 3);

        // Back-to-back results, second one matches
        do_reset();
        begin_search(rnd128());
        hq[0] = rnd128(); cq[0] = {$urandom, $urandom}; gq[0] = 1;
        hq[1] = tgt;      cq[1] = {$urandom, $urandom}; gq[1] = 1;
        drive(0, 1);
        repeat (4) step();
        chk("bb.found", found_a, 1'b1);
        chk("bb.att",   att_a,   2);
        chk("bb.pw",    pw_a,    cq[1]);
        check_both("bb", 2);

        // Reset one cycle after a matching result
        do_reset();
        begin_search(rnd128());
        hash_valid = 1'b1; hash = tgt; cand = {$urandom, $urandom};
        step();
        hash_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r.found", found_a, 1'b0);
        chk("r.att",   att_a,   0);
        chk("r.busy",  busy_a,  1'b0);
        repeat (3) step();
        chk("r.later.found", found_a, 1'b0);

        // Start while busy neither clears attempts nor replaces the target
        begin_search(rnd128());
        hq[0] = rnd128(); cq[0] = {$urandom, $urandom}; gq[0] = 3;
        hq[1] = tgt;      cq[1] = {$urandom, $urandom}; gq[1] = 3;
        drive(0, 0);
        chk("sb.att0", att_a, 1);
        target_hash = rnd128();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("sb.att1", att_a,  1);
        chk("sb.busy", busy_a, 1'b1);
        drive(1, 1);
        repeat (3) step();
        check_both("sb", 2);

        // Restart from FOUND
        tgt = rnd128();
        target_hash = tgt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs.att",   att_a,   0);
        chk("rs.found", found_a, 1'b0);
        chk("rs.busy",  busy_a,  1'b1);
        chk("rs.pw",    pw_a,    0);
        hq[0] = tgt; cq[0] = {$urandom, $urandom}; gq[0] = 1;
        drive(0, 0);
        repeat (3) step();
        check_both("rs", 1);

        // Randomized searches
        for (int it = 0; it < 25; it++) begin
            int n;
            int prev_gap;
            do_reset();
            begin_search(rnd128());
            n = 1 + int'($urandom_range(7, 0));
            prev_gap = 2;
            for (int i = 0; i < n; i++) begin
                hq[i] = ($urandom_range(4, 0) == 0) ? tgt : rnd128();
                cq[i] = {$urandom, $urandom};
                gq[i] = (prev_gap == 1) ? 2 + int'($urandom_range(2, 0))
                                        : 1 + int'($urandom_range(3, 0));
                prev_gap = gq[i];
            end
            drive(0, n - 1);
            repeat (6) step();
            check_both("rnd", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md5_match_checker.md
MD5_MATCH_CHECKER -- requirements
Module: md5_match_checker

Interface
REQ-001 Parameter MAX_TRIES, default 100000000, is the number of candidate hashes after which the search is declared exhausted.
REQ-002 Parameter CNT_W, default 32, is the width of the attempt counter.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the synchronous, active-high reset.
REQ-005 start  input  1  is a one-cycle pulse that begins a search.
REQ-006 target_hash  input  128  is the hash to match; it is sampled on the accepted start.
REQ-007 hash_valid  input  1  is a one-cycle pulse from the hash core meaning hash/cand are a new, stable result.
REQ-008 hash  input  128  is the core's digest, ordered {a,b,c,d}.
REQ-009 cand  input  64  is the eight-ASCII-digit candidate that produced hash.
REQ-010 busy  output  1  is high in SEARCH and CMP.
REQ-011 found  output  1  is a level that is high in FOUND.
REQ-012 exhausted  output  1  is a level that is high in EXHAUST.
REQ-013 found_pw  output  64  is the matching candidate.
REQ-014 attempts  output  CNT_W  is the number of hashes compared since the last accepted start.

Function
REQ-015 The block SHALL implement the states IDLE, SEARCH, CMP, FOUND and EXHAUST.
REQ-016 IDLE->SEARCH on start=1: target_hash is latched, attempts is cleared to 0, and found_pw is cleared to 0.
REQ-017 A start pulse in any state other than IDLE, FOUND or EXHAUST SHALL be ignored.
REQ-018 A start pulse in FOUND or EXHAUST SHALL behave as in IDLE (new search, same cycle).
REQ-019 SEARCH: on hash_valid=1, hash and cand SHALL be registered into a capture stage, and the state goes to CMP.
REQ-020 hash_valid in IDLE, FOUND or EXHAUST SHALL be ignored.
REQ-021 CMP (exactly one cycle): compare the full 128-bit captured hash with the latched target, and increment attempts by 1 (saturating at all-ones).
- match: found_pw <= captured cand; next state FOUND.
- no match, and attempts+1 == MAX_TRIES: next state EXHAUST.
- otherwise: next state SEARCH.
REQ-022 If a match and the MAX_TRIES limit occur in the same CMP cycle, the match SHALL take priority (FOUND).
REQ-023 A hash_valid arriving while in CMP SHALL NOT be lost: it is captured into a one-entry skid register and consumed on the next SEARCH cycle with no extra bubble.
- A third hash_valid while the skid register is full is a protocol violation; the newest value overwrites.
REQ-024 Latency from hash_valid to found=1 SHALL be 2 cycles (capture, compare) when the skid register is empty.
REQ-025 FOUND and EXHAUST SHALL hold found_pw, attempts and their status level until reset or start.
REQ-026 found and exhausted SHALL never be high together.
REQ-027 attempts SHALL be visible and updated every cycle during a search.

Reset
REQ-028 reset=1 SHALL put the block in IDLE and clear the skid and capture registers, target, found_pw=0, attempts=0, busy=0, found=0 and exhausted=0 on the next clock edge.
REQ-029 reset SHALL take priority over start and hash_valid in the same cycle.
REQ-030 reset asserted mid-search SHALL abort the search with no residual match reported.

Verification
REQ-031 Match: start with target_hash=128'hA5A5...A5, then three hash_valid pulses with non-matching hash, then a fourth with hash=A5..A5 and cand="53589793" -> found=1 two cycles after the fourth pulse, found_pw=64'h3533353839373933, attempts=4, busy=0.
REQ-032 Exhaustion: MAX_TRIES=5, six non-matching hash_valid pulses -> exhausted=1 after the fifth compare, attempts=5, sixth pulse ignored, found=0.
REQ-033 Priority: MAX_TRIES=3, third hash matches -> found=1, exhausted=0, attempts=3.
REQ-034 Back-to-back: hash_valid on two consecutive cycles with only the second matching -> found=1, attempts=2, found_pw equals the second cand.
REQ-035 Reset mid-search: reset asserted one cycle after a matching hash_valid -> found=0, attempts=0, state IDLE; a start while busy has no effect on attempts.
REQ-036 Restart: start in FOUND with a new target -> attempts=0, found=0, busy=1 on the next cycle.
